// File: rtl/nav_pwm_pkg.sv
// Shared constants and types for the servo PWM output path.
// Contents: clock rate, frame length, modulation sequence length, pulse clamp limits,
//           and the 21-bit pulse-width type used for Pulse and the frame counter.
package nav_pwm_pkg;

    localparam int CLK_RATE      = 100_000_000;
    localparam int FRAME_LEN     = 2_000_000;    // 100 MHz / 50 Hz
    localparam int NUM_STATES    = 24;
    localparam int MIN_PULSE     = 100_000;      // 1.0 ms
    localparam int NEUTRAL_PULSE = 150_000;      // 1.5 ms
    localparam int MAX_PULSE     = 200_000;      // 2.0 ms

    localparam int PW_W = 21;
    typedef logic [PW_W-1:0] pulse_w_t;

endpackage

// File: rtl/servo_frame_gen.sv
// Frame timer and servo pulse generator: runs the servo frame, steps the modulation
// State once per frame at mid-frame, latches and clamps Pulse at each frame boundary,
// and drives the registered ServoOut line and a FrameStart strobe.
// Ports: CLK, RST_N (sync, active-low), Enable, Pulse[20:0] in;
//        State[4:0], ServoOut, FrameStart out (all registered).
module servo_frame_gen #(
    parameter int FRAME_LEN     = nav_pwm_pkg::FRAME_LEN,
    parameter int NUM_STATES    = nav_pwm_pkg::NUM_STATES,
    parameter int MIN_PULSE     = nav_pwm_pkg::MIN_PULSE,
    parameter int NEUTRAL_PULSE = nav_pwm_pkg::NEUTRAL_PULSE,
    parameter int MAX_PULSE     = nav_pwm_pkg::MAX_PULSE,
    parameter int ADV_POINT     = FRAME_LEN / 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        Enable,
    input  nav_pwm_pkg::pulse_w_t       Pulse,
    output logic [4:0]                  State,
    output logic                        ServoOut,
    output logic                        FrameStart
);

    typedef nav_pwm_pkg::pulse_w_t pw_t;

    localparam pw_t        LAST_CNT   = pw_t'(FRAME_LEN - 1);
    localparam pw_t        ADV_CNT    = pw_t'(ADV_POINT - 1);
    localparam pw_t        MIN_W      = pw_t'(MIN_PULSE);
    localparam pw_t        NEUTRAL_W  = pw_t'(NEUTRAL_PULSE);
    localparam pw_t        MAX_W      = pw_t'(MAX_PULSE);
    localparam logic [4:0] LAST_STATE = 5'(NUM_STATES - 1);

    function automatic pw_t clamp_pulse(input pw_t p);
        if (p < MIN_W)      return MIN_W;
        else if (p > MAX_W) return MAX_W;
        else                return p;
    endfunction

    pw_t  r_cnt;
    pw_t  r_width_q;
    logic r_first_q;

    logic w_wrap;
    logic w_adv;
    pw_t  w_cnt_nxt;
    pw_t  w_width_nxt;

    always_comb begin
        w_wrap      = (r_cnt == LAST_CNT);
        w_adv       = (r_cnt == ADV_CNT);
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
        w_width_nxt = r_width_q;
        // Pulse is only looked at on the boundary edge; the first frame after reset
        // and any frame started while disabled run at neutral width.
        if (w_wrap) begin
            if (r_first_q || !Enable) w_width_nxt = NEUTRAL_W;
            else                      w_width_nxt = clamp_pulse(Pulse);
        end
    end

    // Outputs are derived from next-state counter/width so ServoOut rises on the
    // same edge that starts the frame, with no extra pipeline cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt      <= LAST_CNT;
            r_width_q  <= NEUTRAL_W;
            r_first_q  <= 1'b1;
            State      <= '0;
            ServoOut   <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_width_q  <= w_width_nxt;
            if (w_wrap) r_first_q <= 1'b0;
            ServoOut   <= (w_cnt_nxt < w_width_nxt);
            FrameStart <= w_wrap;
            // Advancing at mid-frame keeps State stable across the boundary, giving
            // the downstream decode time to settle Pulse before it is sampled.
            if (w_adv && Enable) begin
                State <= (State == LAST_STATE) ? 5'd0 : State + 5'd1;
            end
        end
    end

endmodule

// File: doc/servo_frame_gen.md
# servo_frame_gen

- Frame timer and servo-pulse generator for the drive ESC/servo output path.
- Runs the 20 ms servo frame and supplies the 24-step `State` sequence that the pulse-modulation stage decodes.
- Latches that stage's registered `Pulse` width once per frame, clamps it, and drives the single-bit `ServoOut` line to the motor controller.
- It sits directly around the pulse-modulation stage: it produces that stage's `State` input and consumes its `Pulse` output.

## Interface
- `FRAME_LEN`, 2000000: frame period in clocks (100 MHz / 50 Hz); must be > `MAX_PULSE` + 2.
- `NUM_STATES`, 24: length of the modulation state sequence.
- `MIN_PULSE`, 100000: lower clamp, 1 ms.
- `NEUTRAL_PULSE`, 150000: neutral/off width, 1.5 ms.
- `MAX_PULSE`, 200000: upper clamp, 2 ms.
- `ADV_POINT`, `FRAME_LEN`/2: frame count at which `State` advances; must be > `MAX_PULSE` and < `FRAME_LEN`-1.
- `CLK` input, 1 bit: system clock. One clock domain only.
- `RST_N` input, 1 bit: reset, synchronous, active-low.
- `Enable` input, 1 bit: 0 forces neutral output and freezes `State`.
- `Pulse` input, 21 bits: requested high time in clocks, from the pulse-modulation stage.
- `State` output, 5 bits: modulation step, range 0..`NUM_STATES`-1.
- `ServoOut` output, 1 bit: servo PWM line, registered.
- `FrameStart` output, 1 bit: one-cycle strobe on the first cycle of each frame, registered.

## Operation
- **Registers:**
  - `cnt`, 21 bits: frame counter.
  - `width_q`, 21 bits: width in use for the current frame.
  - `first_q`: set until the first frame after reset has started.
  - `State`.
- **Reset** (`RST_N`=0 at a `CLK` edge):
  - `cnt` ← `FRAME_LEN`-1.
  - `width_q` ← `NEUTRAL_PULSE`.
  - `first_q` ← 1.
  - `State` ← 0, `ServoOut` ← 0, `FrameStart` ← 0.
  - Reset mid-frame aborts the frame immediately; there is no partial pulse completion.
- **Counter:** `cnt` increments each cycle; at `FRAME_LEN`-1 it wraps to 0.
- **Frame boundary** (the edge where `cnt` goes `FRAME_LEN`-1 → 0), `width_q` loads:
  - `NEUTRAL_PULSE` if `first_q`=1 or `Enable`=0. `first_q` then clears.
  - Otherwise the clamped value of `Pulse`: below `MIN_PULSE` → `MIN_PULSE`; above `MAX_PULSE` → `MAX_PULSE`; else `Pulse`. `Pulse`=0 gives `MIN_PULSE`.
- **`Pulse` sampling:** `Pulse` is sampled only at the boundary edge. Changes at any other time have no effect until the next frame.
- **`ServoOut`:** high exactly while `cnt` < `width_q`. It is computed from the next-state values, so it is high for exactly `width_q` cycles starting on the cycle where `cnt`=0.
- **`FrameStart`:** 1 exactly on the cycles where `cnt`=0.
- **`State` advance:** on the edge where `cnt` goes `ADV_POINT`-1 → `ADV_POINT`, if `Enable`=1, `State` ← (`State`=`NUM_STATES`-1) ? 0 : `State`+1. If `Enable`=0, `State` holds.
- **`State` timing relative to `Pulse`:** `State` is stable from mid-frame through the next boundary. This gives the pulse-modulation stage's one-cycle registered decode ample time to settle before `Pulse` is sampled.
- **`Enable` changes** take effect on `ServoOut` only at the next frame boundary. `State` reacts at the next `ADV_POINT`.

## Timing
- **First frame:** on the first edge with `RST_N`=1, `cnt`=0, `FrameStart`=1 and `ServoOut`=1. The first frame is always `NEUTRAL_PULSE` wide.
- **Latency:** a `Pulse` value stable at boundary edge N appears as `ServoOut` width in the frame beginning at that edge. Latency from that edge to the rising edge of `ServoOut` is 0 cycles.
- **Period:** `ServoOut` rising edges are exactly `FRAME_LEN` cycles apart. There is no jitter.
- **`State` sequence:** advances once per frame when enabled; period `NUM_STATES` frames (24 × 20 ms = 480 ms).
- **Arithmetic:** all comparisons are unsigned 21-bit. `FRAME_LEN`-1 must fit in 21 bits.

## Structure
- **Shared package** (`nav_pwm_pkg`): `CLK_RATE`, `FRAME_LEN`, `NUM_STATES`, `MIN_PULSE`, `NEUTRAL_PULSE`, `MAX_PULSE`, plus a 21-bit pulse-width typedef.
- **Sub-modules:** none required. The clamp is a local function inside this module.
- **Expected size:** roughly 120–180 lines.

## Test plan
All scenarios use `FRAME_LEN`=2000, `MIN`=100, `NEUTRAL`=150, `MAX`=200, `ADV_POINT`=1000.
- **Reset release:** release reset with `Pulse`=180 and `Enable`=1 → frame 0 `ServoOut` high for 150 cycles; frame 1 high for 180 cycles; `FrameStart` strobes 2000 cycles apart.
- **Clamping:** `Pulse`=0, then 50, then 250, then 200 on successive frames → widths 100, 100, 200, 200.
- **`State` wrap:** run 25 frames with `Enable`=1 → `State` changes at cnt=1000 each frame, reads 0,1,…,23,0,1 across frames, with no change at a frame boundary.
- **Enable low:** drop `Enable` at cnt=500 in a frame with width 180 → that frame stays 180 wide; `State` frozen from that frame's `ADV_POINT`; subsequent frames are 150 wide.
- **Mid-frame `Pulse` change:** change `Pulse` 120→190 at cnt=50 → the current frame stays 120 wide; the next frame is 190 wide.
- **Reset mid-pulse:** assert `RST_N`=0 at cnt=60 → `ServoOut`, `FrameStart` and `State` all 0 on the next edge; the behaviour after release matches the first scenario.
